flop_pipeline: RTL and testbench



---
 rtl/flop_pipeline_pkg.sv | 9 +
 rtl/flop_pipeline_if.sv | 26 ++
 rtl/flop_pipeline_stage.sv | 28 ++
 rtl/flop_pipeline.sv | 63 ++++++
 tb/tb_flop_pipeline.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/flop_pipeline_pkg.sv
// flop_pipeline_pkg: shared defaults and sizing helpers for the elastic pipeline
package flop_pipeline_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/flop_pipeline_if.sv
// flop_pipeline_if: upstream/downstream handshake bundle for flop_pipeline
interface flop_pipeline_if #(
    parameter int WIDTH = flop_pipeline_pkg::DEF_WIDTH,
    parameter int DEPTH = flop_pipeline_pkg::DEF_DEPTH
);
    localparam int CW = flop_pipeline_pkg::count_width(DEPTH);
    logic             sync_clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [CW-1:0]    count;

    modport master (
        output sync_clear, in_valid, d, out_ready,
        input  in_ready, out_valid, q, qbar, count
    );

    modport slave (
        input  sync_clear, in_valid, d, out_ready,
        output in_ready, out_valid, q, qbar, count
    );
endinterface

// File: rtl/flop_pipeline_stage.sv
// flop_pipeline_stage: one data register plus valid bit with async reset and sync clear
module flop_pipeline_stage #(
    parameter int               WIDTH       = flop_pipeline_pkg::DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);
    // data holds unless loaded; valid stays set while refilled in the same cycle it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= RESET_VALUE;
            valid <= 1'b0;
        end else if (clear) begin
            q     <= RESET_VALUE;
            valid <= 1'b0;
        end else begin
            if (load) q <= d;
            valid <= load | (valid & !unload);
        end
    end
endmodule

// File: rtl/flop_pipeline.sv
// flop_pipeline: elastic DEPTH-stage register pipeline with bubble collapsing
module flop_pipeline
    import flop_pipeline_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               DEPTH       = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic            clk,
    input logic            reset,
    flop_pipeline_if.slave bus
);
    localparam int CW = count_width(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] src  [DEPTH];
    logic             accept;
    logic [CW-1:0]    cnt;

    // ready ripples back from out_ready so an occupied stage can load when it drains
    always_comb begin
        rdy[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            move[i] = valid[i] & rdy[i+1];
            rdy[i]  = !valid[i] | move[i];
        end
        accept  = bus.in_valid & rdy[0] & !bus.sync_clear;
        load[0] = accept;
        src[0]  = bus.d;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = move[i-1];
            src[i]  = data[i-1];
        end
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(valid[i]);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        flop_pipeline_stage #(
            .WIDTH(WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_stage (
            .clk(clk),
            .reset(reset),
            .clear(bus.sync_clear),
            .load(load[i]),
            .unload(move[i]),
            .d(src[i]),
            .q(data[i]),
            .valid(valid[i])
        );
    end

    assign bus.in_ready  = rdy[0] & !bus.sync_clear;
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.q         = data[DEPTH-1];
    assign bus.qbar      = ~data[DEPTH-1];
    assign bus.count     = cnt;
endmodule

// File: tb/tb_flop_pipeline.sv
// tb_flop_pipeline: scoreboard bench for DEPTH=2 and DEPTH=1 pipelines
module tb_flop_pipeline;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_q1[$];
    logic [3:0] e, nb, e1, nb1;

    always #5 clk = ~clk;

    flop_pipeline_if #(.WIDTH(4), .DEPTH(2)) bus ();
    flop_pipeline_if #(.WIDTH(4), .DEPTH(1)) bus1 ();

    flop_pipeline #(.WIDTH(4), .DEPTH(2), .RESET_VALUE(4'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    flop_pipeline #(.WIDTH(4), .DEPTH(1), .RESET_VALUE(4'h0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // output monitors: every completed transfer must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL d2 out: got word %0h expected none", bus.q);
            end else begin
                e = exp_q.pop_front();
                nb = ~e;
                check("d2 out q", bus.q, e);
                check("d2 out qbar", bus.qbar, nb);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            if (exp_q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL d1 out: got word %0h expected none", bus1.q);
            end else begin
                e1 = exp_q1.pop_front();
                nb1 = ~e1;
                check("d1 out q", bus1.q, e1);
                check("d1 out qbar", bus1.qbar, nb1);
            end
        end
    end

    task automatic send(input logic [3:0] v);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.d = v;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send accepted", bus.in_ready, 1);
        if (bus.in_ready) exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.sync_clear = 0; bus.in_valid = 0; bus.d = 0; bus.out_ready = 0;
        bus1.sync_clear = 0; bus1.in_valid = 0; bus1.d = 0; bus1.out_ready = 0;
        #2;
        check("reset out_valid", bus.out_valid, 0);
        check("reset q", bus.q, 4'h0);
        check("reset qbar", bus.qbar, 4'hF);
        check("reset count", bus.count, 0);
        check("reset in_ready", bus.in_ready, 1);
        check("d1 reset in_ready", bus1.in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // streaming 1..4 back-to-back, first word visible two edges after acceptance
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.d = 4'(k);
            @(negedge clk);
            check("stream in_ready", bus.in_ready, 1);
            check("stream latency out_valid", bus.out_valid, (k >= 3));
            exp_q.push_back(4'(k));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stream drained", exp_q.size(), 0);
        // backpressure: 5 and 6 fill the pipe, 7 waits for out_ready
        bus.out_ready = 1'b0;
        fork
            begin
                send(4'h5);
                send(4'h6);
                send(4'h7);
            end
        join_none
        repeat (3) @(negedge clk);
        check("bp count", bus.count, 2);
        check("bp in_ready", bus.in_ready, 0);
        check("bp out_valid", bus.out_valid, 1);
        check("bp q", bus.q, 4'h5);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp drained", exp_q.size(), 0);
        check("bp count empty", bus.count, 0);
        // bubble collapse: 8, idle cycle, 9 with downstream stalled
        bus.out_ready = 1'b0;
        send(4'h8);
        @(posedge clk);
        #1;
        send(4'h9);
        @(negedge clk);
        check("bubble count", bus.count, 2);
        check("bubble in_ready", bus.in_ready, 0);
        check("bubble q", bus.q, 4'h8);
        // sync_clear with a full pipe; the word offered during clear is dropped
        @(posedge clk);
        #1;
        bus.sync_clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.d = 4'hF;
        @(negedge clk);
        check("clear in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.sync_clear = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("clear count", bus.count, 0);
        check("clear out_valid", bus.out_valid, 0);
        check("clear q", bus.q, 4'h0);
        check("clear qbar", bus.qbar, 4'hF);
        // asynchronous reset mid-cycle while holding A
        @(posedge clk);
        #1;
        send(4'hA);
        @(posedge clk);
        @(negedge clk);
        check("hold q", bus.q, 4'hA);
        check("hold count", bus.count, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async q", bus.q, 4'h0);
        check("async qbar", bus.qbar, 4'hF);
        check("async out_valid", bus.out_valid, 0);
        check("async count", bus.count, 0);
        exp_q.delete();
        #2;
        reset = 1'b0;
        // DEPTH=1: full with out_ready accepts and emits on the same edge
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.d = 4'h3;
        @(negedge clk);
        check("d1 in_ready empty", bus1.in_ready, 1);
        exp_q1.push_back(4'h3);
        @(posedge clk);
        #1;
        bus1.d = 4'hC;
        @(negedge clk);
        check("d1 full count", bus1.count, 1);
        check("d1 full in_ready", bus1.in_ready, 1);
        exp_q1.push_back(4'hC);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        bus1.d = 4'h5;
        @(negedge clk);
        check("d1 count held", bus1.count, 1);
        check("d1 q", bus1.q, 4'hC);
        check("d1 stalled in_ready", bus1.in_ready, 0);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("d1 drained", exp_q1.size(), 0);
        check("d1 count empty", bus1.count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
